// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package hazard_pkg;

  // Scoreboard rd field is wide enough for any REG_AW up to 8.
  localparam int unsigned SB_RD_W     = 8;
  localparam int unsigned FWD_RF      = 0;
  localparam int unsigned STALL_CNT_W = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand youngest-first match over the writer scoreboard.
// HAZARD_FWD_EN selects forwarding; otherwise any non-writeback match stalls.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int FW     = $clog2(DEPTH + 1)
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  sb_entry_t         sb [DEPTH],
  output logic [FW-1:0]     fwd_sel_c,
  output logic              hazard_c
);

  logic req_c;
  assign req_c = id_valid && rs_used && (rs != '0);

  // Scan oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    fwd_sel_c = FW'(FWD_RF);
    hazard_c  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_c && sb[i].valid && (sb[i].rd == SB_RD_W'(rs))) begin
`ifdef HAZARD_FWD_EN
        if (sb[i].is_load && (i < DEPTH - 1)) begin
          fwd_sel_c = FW'(FWD_RF);
          hazard_c  = 1'b1;
        end else begin
          fwd_sel_c = FW'(i + 1);
          hazard_c  = 1'b0;
        end
`else
        hazard_c = (i < DEPTH - 1);
`endif
      end
    end
  end

`ifndef HAZARD_FWD_EN
  // Load flag is irrelevant when every in-flight match stalls.
  logic unused_is_load;
  always_comb begin
    unused_is_load = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      unused_is_load = unused_is_load ^ sb[i].is_load;
    end
  end
`endif

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding control for a 1..4 stage post-decode pipeline.
// Define HAZARD_FWD_EN to enable operand forwarding (else fwd selects are 0).
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int FW     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_rf_en,
  input  logic                   id_is_load,
  input  logic                   br_taken,
  input  logic                   mem_hold,
  output logic                   stall,
  output logic                   bubble,
  output logic                   flush,
  output logic [FW-1:0]          fwd_sel_a,
  output logic [FW-1:0]          fwd_sel_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  sb_entry_t sb_q [DEPTH];
  sb_entry_t ins_entry_c;
  logic      hazard_a_c;
  logic      hazard_b_c;
  logic      hazard_c;

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_match_a (
    .id_valid  (id_valid),
    .rs        (id_rs1),
    .rs_used   (id_rs1_used),
    .sb        (sb_q),
    .fwd_sel_c (fwd_sel_a),
    .hazard_c  (hazard_a_c)
  );

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_match_b (
    .id_valid  (id_valid),
    .rs        (id_rs2),
    .rs_used   (id_rs2_used),
    .sb        (sb_q),
    .fwd_sel_c (fwd_sel_b),
    .hazard_c  (hazard_b_c)
  );

  // A redirect squashes the hazard; a memory wait always freezes.
  always_comb begin
    hazard_c = hazard_a_c || hazard_b_c;
    stall    = mem_hold || (hazard_c && !br_taken);
    bubble   = hazard_c && !br_taken && !mem_hold;
    flush    = br_taken;
  end

  always_comb begin
    ins_entry_c         = '0;
    ins_entry_c.rd      = SB_RD_W'(id_rd);
    ins_entry_c.is_load = id_is_load;
    ins_entry_c.valid   = id_valid && id_rf_en && (id_rd != '0) && !stall && !br_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      stall_count <= '0;
    end else begin
      if (!mem_hold) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          sb_q[k] <= sb_q[k-1];
        end
        sb_q[0] <= ins_entry_c;
      end
      if (stall && (stall_count != STALL_CNT_MAX)) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the in-order RV32 pipeline. It tracks in-flight register writers in a shift-register scoreboard spanning DEPTH post-decode stages. It drives stall, bubble and flush controls for the fetch/decode pipeline buffers and per-operand forwarding selects for the execute operand muxes. It sits beside the decode stage and generalises the fixed 3-stage pipeline to 1–4 post-decode stages.

## Interface
Parameters:
- REG_AW, 5, register-index width
- DEPTH, 2, post-decode stages holding writers (1..4); stage DEPTH is writeback
- FW, $clog2(DEPTH+1), forwarding-select width

Ports:
- clk  in  1  clock
- rst  in  1  reset (one clock; synchronous, active-high)
- id_valid  in  1  decode slot holds an instruction
- id_rs1, id_rs2  in  REG_AW  source indices
- id_rs1_used, id_rs2_used  in  1  operand actually read
- id_rd  in  REG_AW  destination index
- id_rf_en  in  1  instruction writes register file
- id_is_load  in  1  instruction is a load (data ready only at stage DEPTH)
- br_taken  in  1  redirect (branch/jump/trap/mret) resolved this cycle
- mem_hold  in  1  data memory wait; freezes the pipeline
- stall  out  1  hold PC and IF/ID buffer
- bubble  out  1  insert NOP into ID/EX buffer
- flush  out  1  clear IF/ID buffer
- fwd_sel_a, fwd_sel_b  out  FW  0 = register file, k = stage k result
- stall_count  out  32  saturating hazard-stall counter

## Operation
- Scoreboard: DEPTH entries {valid, rd, is_load}; stage 1 is youngest.
- Match on operand x: id_valid & x_used & x≠0 & entry.valid & entry.rd==x. The youngest match (lowest k) has priority.
- Forward: youngest match at k where !is_load or k==DEPTH → fwd_sel=k. No match → 0.
- Load-use: youngest match is a load with k<DEPTH → hazard. Older matches are ignored.
- hazard = load-use on either operand.
- stall = (hazard | mem_hold) & !br_taken; also stall = 1 whenever mem_hold=1.
- bubble = hazard & !br_taken & !mem_hold.
- flush = br_taken.
- Scoreboard shift when mem_hold=0:
  - stage k+1 ← stage k; the stage-DEPTH entry retires.
  - stage 1 ← {1, id_rd, id_is_load} if id_valid & id_rf_en & id_rd≠0 & !stall & !br_taken; otherwise invalid.
- mem_hold=1: scoreboard holds, bubble=0, fwd selects remain valid.
- Simultaneous br_taken and hazard: flush wins, stall=0, no entry inserted. Older entries are kept.
- stall_count increments on each cycle with stall=1 and saturates at 0xFFFF_FFFF.

## Timing
- stall, bubble, flush and fwd_sel are combinational from the scoreboard and id_* inputs in the same cycle.
- The scoreboard and stall_count update on the rising clk edge.
- Load-use penalty is DEPTH−k cycles; DEPTH=2 gives 1 stall cycle for an adjacent consumer.
- Reset: all entries invalid and stall_count=0. The combinational outputs are therefore 0 given idle inputs.
- rst during a hold or stall clears state on that edge; br_taken and mem_hold have no effect while rst=1.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- HAZARD_FWD_EN undefined:
  - fwd_sel_a and fwd_sel_b are tied to 0.
  - Any match in stages 1..DEPTH−1 is a hazard (stall+bubble).
  - A stage-DEPTH match does not stall; the register file is write-before-read.

## Structure
- hazard_pkg: sb_entry_t struct, FWD_RF=0 constant, and the stall_count saturation constant.
- Sub-module hazard_match: combinational per-operand priority match over the scoreboard, producing fwd_sel and hazard. It is instantiated twice, once per operand.

## Test plan
- rst=1 for 2 cycles, idle inputs → stall=0, bubble=0, flush=0, fwd_sel_a=fwd_sel_b=0, stall_count=0.
- DEPTH=2: ALU writer rd=5, next cycle rs1=5 → fwd_sel_a=1, stall=0. A non-writer follows, then rs2=5 → fwd_sel_b=2.
- Load rd=7, next cycle rs1=7 → stall=1 and bubble=1 for 1 cycle, then fwd_sel_a=2 and stall_count=1. Without HAZARD_FWD_EN: 1 stall cycle, then fwd_sel_a=0.
- Writer rd=0, then rs1=0 → no stall, fwd_sel_a=0, and stage 1 stays invalid.
- Load rd=7, then consumer rs1=7 with br_taken=1 in the same cycle → flush=1, stall=0, bubble=0. Next cycle stage 1 is invalid.
- mem_hold=1 for 3 cycles after writer rd=9 → scoreboard frozen, stall=1, stall_count +3. rs2=9 keeps fwd_sel_b=1 throughout.
